// File: rtl/controller_counter_capture_pio_if.sv
// Avalon-MM slave bus for the counter capture PIO: register access plus the
// level interrupt back to the host.
interface controller_counter_capture_pio_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  // Reads have no handshake: readdata follows address one cycle later every
  // cycle; a write lands on the edge where chipselect=1 and write_n=0.
  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/controller_counter_capture_pio.sv
// Multi-channel counter capture PIO: synchronises counter buses, offers live and
// coherent snapshot reads, and flags changes with a maskable W1C interrupt.
module controller_counter_capture_pio #(
  parameter int WIDTH       = 10,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  controller_counter_capture_pio_if.slave bus
);

  localparam logic [3:0] ADDR_CHANGE  = 4'h8;
  localparam logic [3:0] ADDR_MASK    = 4'h9;
  localparam logic [3:0] ADDR_CONTROL = 4'hA;

  logic [CHANNELS*WIDTH-1:0] sync_pipe [SYNC_STAGES];
  logic [CHANNELS*WIDTH-1:0] sync_bus;
  logic [CHANNELS*WIDTH-1:0] prev_bus;
  logic [WIDTH-1:0]          snap [CHANNELS];
  logic [CHANNELS-1:0]       change_q;
  logic [CHANNELS-1:0]       change_d;
  logic [CHANNELS-1:0]       irq_mask_q;
  logic [CHANNELS-1:0]       diff;
  logic [CHANNELS-1:0]       clear_bits;
  logic                      wr_en;
  logic                      change_wr;
  logic                      mask_wr;
  logic                      snap_trig;
  logic [31:0]               rd_mux;
  logic                      unused_wdata;

  assign sync_bus     = sync_pipe[SYNC_STAGES-1];
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign change_wr    = wr_en && (bus.address == ADDR_CHANGE);
  assign mask_wr      = wr_en && (bus.address == ADDR_MASK);
  assign snap_trig    = wr_en && (bus.address == ADDR_CONTROL) && bus.writedata[0];
  assign clear_bits   = change_wr ? bus.writedata[CHANNELS-1:0] : '0;
  assign unused_wdata = ^bus.writedata[31:CHANNELS];

  // A fresh difference overrides a same-edge W1C so no event is lost.
  always_comb begin
    diff = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      diff[n] = (sync_bus[n*WIDTH +: WIDTH] != prev_bus[n*WIDTH +: WIDTH]);
    end
    change_d = diff | (change_q & ~clear_bits);
  end

  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (bus.address == 4'(n))     rd_mux[WIDTH-1:0] = sync_bus[n*WIDTH +: WIDTH];
      if (bus.address == 4'(n + 4)) rd_mux[WIDTH-1:0] = snap[n];
    end
    case (bus.address)
      ADDR_CHANGE: rd_mux[CHANNELS-1:0] = change_q;
      ADDR_MASK:   rd_mux[CHANNELS-1:0] = irq_mask_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
    end else begin
      sync_pipe[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_bus     <= '0;
      change_q     <= '0;
      irq_mask_q   <= '0;
      bus.irq      <= 1'b0;
      bus.readdata <= '0;
      for (int n = 0; n < CHANNELS; n++) snap[n] <= '0;
    end else begin
      prev_bus     <= sync_bus;
      change_q     <= change_d;
      bus.irq      <= |(change_q & irq_mask_q);
      bus.readdata <= rd_mux;
      if (mask_wr) irq_mask_q <= bus.writedata[CHANNELS-1:0];
      // All channels capture on the same edge, giving a coherent snapshot.
      if (snap_trig) begin
        for (int n = 0; n < CHANNELS; n++) snap[n] <= sync_bus[n*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_controller_counter_capture_pio.sv
// Bench for controller_counter_capture_pio: directed scenarios plus random
// traffic, all checked every cycle against a behavioural register model.
module tb_controller_counter_capture_pio;
  localparam int WIDTH       = 10;
  localparam int CHANNELS    = 2;
  localparam int SYNC_STAGES = 2;
  localparam int PW          = CHANNELS * WIDTH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [PW-1:0] in_port = '0;
  int            n_tests = 0;
  int            n_fail = 0;

  controller_counter_capture_pio_if bus ();

  controller_counter_capture_pio #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [PW-1:0]       m_hist[$];   // in_port samples, newest first
  logic [WIDTH-1:0]    m_sync [CHANNELS];
  logic [WIDTH-1:0]    m_prev [CHANNELS];
  logic [WIDTH-1:0]    m_snap [CHANNELS];
  logic [CHANNELS-1:0] m_change;
  logic [CHANNELS-1:0] m_mask;
  logic                m_irq;
  logic [31:0]         m_rd;

  function automatic logic [WIDTH-1:0] chan(input logic [PW-1:0] v, input int n);
    return v[n*WIDTH +: WIDTH];
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r;
    r = 0;
    if (a < 4 && a < CHANNELS) r = 32'(m_sync[a]);
    else if (a >= 4 && a < 8 && (a - 4) < CHANNELS) r = 32'(m_snap[a-4]);
    else if (a == 8) r = 32'(m_change);
    else if (a == 9) r = 32'(m_mask);
    return r;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back('0);
    for (int n = 0; n < CHANNELS; n++) begin
      m_sync[n] = '0; m_prev[n] = '0; m_snap[n] = '0;
    end
    m_change = '0; m_mask = '0; m_irq = 1'b0; m_rd = '0;
  endtask

  // One clock edge: everything is computed from the state before the edge.
  task automatic model_step();
    logic [31:0]         new_rd;
    logic                new_irq;
    logic [CHANNELS-1:0] new_change;
    logic                wr;
    int                  a;
    a       = int'(bus.address);
    new_rd  = model_read(a);
    new_irq = |(m_change & m_mask);
    wr      = bus.chipselect && !bus.write_n;
    new_change = m_change;
    if (wr && a == 8) new_change = new_change & ~bus.writedata[CHANNELS-1:0];
    for (int n = 0; n < CHANNELS; n++)
      if (m_sync[n] != m_prev[n]) new_change[n] = 1'b1;
    if (wr && a == 9) m_mask = bus.writedata[CHANNELS-1:0];
    if (wr && a == 10 && bus.writedata[0])
      for (int n = 0; n < CHANNELS; n++) m_snap[n] = m_sync[n];
    // sync shows in_port as it was SYNC_STAGES edges ago
    m_hist.push_front(in_port);
    void'(m_hist.pop_back());
    for (int n = 0; n < CHANNELS; n++) begin
      m_prev[n] = m_sync[n];
      m_sync[n] = chan(m_hist[SYNC_STAGES-1], n);
    end
    m_change = new_change;
    m_irq    = new_irq;
    m_rd     = new_rd;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      model_step();
      #1;
      if (reset_n) begin
        check("model_rd", bus.readdata, m_rd);
        check("model_irq", 32'(bus.irq), 32'(m_irq));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    check(tag, bus.readdata, exp);
  endtask

  task automatic set_ch(input int n, input logic [WIDTH-1:0] v);
    in_port[n*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    bus.address = '0;
    bus_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd", bus.readdata, 32'h0);
    check("reset_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd("reset_change", 4'h8, 32'h0);

    // live data and change flag, interrupt masked
    @(negedge clk); set_ch(1, 10'h2A5);
    wait_cycles(SYNC_STAGES + 2);
    rd("data1", 4'h1, 32'h0000_02A5);
    rd("change_ch1", 4'h8, 32'h2);
    check("irq_masked", 32'(bus.irq), 32'h0);

    // interrupt raise and W1C clear; upper writedata bits ignored
    wr(4'h9, 32'hFFFF_FFF2);
    rd("mask_rd", 4'h9, 32'h2);
    wr(4'h8, 32'h3);
    @(negedge clk); set_ch(1, 10'h2A6);
    wait_cycles(SYNC_STAGES + 3);
    check("irq_rise", 32'(bus.irq), 32'h1);
    wr(4'h8, 32'h2);
    @(negedge clk);
    check("irq_fall", 32'(bus.irq), 32'h0);

    // coherent snapshot
    @(negedge clk); set_ch(0, 10'h3FF); set_ch(1, 10'h155);
    wait_cycles(SYNC_STAGES + 2);
    wr(4'hA, 32'h1);
    @(negedge clk); set_ch(0, 10'h001); set_ch(1, 10'h002);
    wait_cycles(SYNC_STAGES + 2);
    rd("snap0", 4'h4, 32'h3FF);
    rd("snap1", 4'h5, 32'h155);
    rd("data0_new", 4'h0, 32'h001);
    rd("data1_new", 4'h1, 32'h002);

    // set and clear on the same edge: set wins
    wr(4'h8, 32'h3);
    wait_cycles(2);
    @(negedge clk); set_ch(0, 10'h0AA);
    repeat (SYNC_STAGES - 1) @(negedge clk);
    wr(4'h8, 32'h1);
    rd("set_wins", 4'h8, 32'h1);

    // unmapped and out-of-range reads
    rd("unmapped_2", 4'h2, 32'h0);
    rd("unmapped_6", 4'h6, 32'h0);
    rd("unmapped_b", 4'hB, 32'h0);
    rd("unmapped_f", 4'hF, 32'h0);
    rd("control_rd", 4'hA, 32'h0);

    // rollover is an ordinary change
    @(negedge clk); set_ch(0, 10'h3FF);
    wait_cycles(SYNC_STAGES + 3);
    wr(4'h8, 32'h3);
    wait_cycles(1);
    @(negedge clk); set_ch(0, 10'h000);
    wait_cycles(SYNC_STAGES + 2);
    rd("rollover", 4'h8, 32'h1);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus_idle();
      if ($urandom_range(0, 3) == 0) begin
        int n;
        n = int'($urandom_range(0, CHANNELS - 1));
        set_ch(n, WIDTH'($urandom));
      end
      bus.address = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin
          bus.chipselect = 1'b1; bus.write_n = 1'b0;
          bus.address    = 4'($urandom_range(8, 10));
          bus.writedata  = $urandom;
        end
        1: begin
          bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = $urandom;
        end
        2: bus.chipselect = 1'b1;
        default: ;
      endcase
    end

    // asynchronous reset in the middle of a snapshot write
    @(negedge clk);
    bus.address = 4'hA; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h1;
    set_ch(0, 10'h123); set_ch(1, 10'h321);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_rd", bus.readdata, 32'h0);
    check("async_rst_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    reset_n = 1'b1;
    rd("rst_snap0", 4'h4, 32'h0);
    rd("rst_mask", 4'h9, 32'h0);
    wait_cycles(SYNC_STAGES + 2);
    rd("rst_nonzero_in", 4'h8, 32'h3);
    wait_cycles(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
